// File: rtl/crypt_pkg.sv
// Shared YODA crypt link definitions: widths, FSM state codes and rotate helpers.
// Used by both the Encrypter and the Decrypter.
package crypt_pkg;

    localparam int unsigned ENCRYPTER_WIDTH    = 16;
    localparam int unsigned KEY_WIDTH          = 16;
    localparam int unsigned KEY_ROTATION_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_DECRYPT  = 3'd2,
        ST_OUT      = 3'd3,
        ST_WAIT_CAP = 3'd4
    } crypt_state_t;

    // Rotating a doubled copy keeps the shift amount in range for r = 0.
    function automatic logic [ENCRYPTER_WIDTH-1:0] rotl(
        input logic [ENCRYPTER_WIDTH-1:0]    x,
        input logic [KEY_ROTATION_WIDTH-1:0] r
    );
        logic [2*ENCRYPTER_WIDTH-1:0] t;
        t = {x, x} << r;
        return t[2*ENCRYPTER_WIDTH-1:ENCRYPTER_WIDTH];
    endfunction

    function automatic logic [ENCRYPTER_WIDTH-1:0] rotr(
        input logic [ENCRYPTER_WIDTH-1:0]    x,
        input logic [KEY_ROTATION_WIDTH-1:0] r
    );
        logic [2*ENCRYPTER_WIDTH-1:0] t;
        t = {x, x} >> r;
        return t[ENCRYPTER_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/decrypt_core.sv
// Combinational inverse of the Encrypter transform: P = ROTR(C,r) ^ ROTL(K,r).
module decrypt_core
    import crypt_pkg::*;
(
    input  logic [ENCRYPTER_WIDTH-1:0]    c_i,
    input  logic [KEY_ROTATION_WIDTH-1:0] r_i,
    input  logic [KEY_WIDTH-1:0]          k_i,
    output logic [ENCRYPTER_WIDTH-1:0]    p_o
);

    assign p_o = rotr(c_i, r_i) ^ rotl(k_i, r_i);

endmodule

// File: rtl/decrypter.sv
// YODA link receive end: four-phase fetch of cipher words, decrypt, four-phase hand-off.
// Optional macro DECRYPTER_KEY_ROLL_EN rolls the key left by one after every delivered word.
module decrypter
    import crypt_pkg::*;
#(
    parameter int unsigned WIDTH = ENCRYPTER_WIDTH,
    parameter int unsigned KEY_W = KEY_WIDTH,
    parameter int unsigned ROT_W = KEY_ROTATION_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [ROT_W-1:0] rot_offset,
    input  logic             rdyIn,
    input  logic             cap,
    input  logic             prog,
    output logic [WIDTH-1:0] dataOut,
    output logic             reqIn,
    output logic             reqOut,
    output logic [2:0]       state,
    output logic [KEY_W-1:0] key
);

    crypt_state_t     state_q;
    logic [WIDTH-1:0] c_q;
    logic [ROT_W-1:0] r_q;
    logic [KEY_W-1:0] key_q;
    logic [WIDTH-1:0] dataOut_q;
    logic             reqIn_q;
    logic             reqOut_q;
    logic [WIDTH-1:0] plain_d;

    decrypt_core u_core (
        .c_i (c_q),
        .r_i (r_q),
        .k_i (key_q),
        .p_o (plain_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            r_q       <= '0;
            key_q     <= '0;
            dataOut_q <= '0;
            reqIn_q   <= 1'b0;
            reqOut_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (prog) begin
                        key_q   <= dataIn;
                        reqIn_q <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A key load takes precedence over a word offered on the same edge.
                    if (prog) begin
                        key_q <= dataIn;
                    end else if (rdyIn) begin
                        c_q     <= dataIn;
                        r_q     <= rot_offset;
                        reqIn_q <= 1'b0;
                        state_q <= ST_DECRYPT;
                    end
                end
                ST_DECRYPT: begin
                    dataOut_q <= plain_d;
                    reqOut_q  <= 1'b1;
                    state_q   <= ST_OUT;
                end
                ST_OUT: begin
                    if (cap) begin
                        reqOut_q <= 1'b0;
                        state_q  <= ST_WAIT_CAP;
                    end
                end
                ST_WAIT_CAP: begin
                    // Both acks must be released before the next request is raised.
                    if (!cap && !rdyIn) begin
                        reqIn_q <= 1'b1;
                        state_q <= ST_REQ;
`ifdef DECRYPTER_KEY_ROLL_EN
                        key_q   <= rotl(key_q, ROT_W'(1));
`endif
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    c_q       <= '0;
                    r_q       <= '0;
                    key_q     <= '0;
                    dataOut_q <= '0;
                    reqIn_q   <= 1'b0;
                    reqOut_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut = dataOut_q;
    assign reqIn   = reqIn_q;
    assign reqOut  = reqOut_q;
    assign state   = state_q;
    assign key     = key_q;

endmodule

// File: tb/tb_decrypter.sv
// Scoreboard bench for decrypter: driver pushes expected plaintext, monitor pops on reqOut rise.
module tb_decrypter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic [3:0]  rot_offset;
    logic        rdyIn, cap, prog;
    logic [15:0] dataOut;
    logic        reqIn, reqOut;
    logic [2:0]  state;
    logic [15:0] key;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_key;
    logic        ro_prev = 1'b0;

    always #5 clk = ~clk;

    decrypter dut (
        .clk        (clk),
        .reset      (reset),
        .dataIn     (dataIn),
        .rot_offset (rot_offset),
        .rdyIn      (rdyIn),
        .cap        (cap),
        .prog       (prog),
        .dataOut    (dataOut),
        .reqIn      (reqIn),
        .reqOut     (reqOut),
        .state      (state),
        .key        (key)
    );

    // Reference rotates defined bit by bit with modular indexing.
    function automatic logic [15:0] m_rotl(input logic [15:0] x, input int r);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[(i + r) % 16] = x[i];
        return y;
    endfunction

    function automatic logic [15:0] m_rotr(input logic [15:0] x, input int r);
        logic [15:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[i] = x[(i + r) % 16];
        return y;
    endfunction

    function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [15:0] k, input int r);
        return m_rotl(p ^ m_rotl(k, r), r);
    endfunction

    function automatic logic [15:0] m_dec(input logic [15:0] c, input logic [15:0] k, input int r);
        return m_rotr(c, r) ^ m_rotl(k, r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reqOut && !ro_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none", dataOut);
            end else begin
                check("dataOut", {16'h0, dataOut}, {16'h0, exp_q.pop_front()});
            end
        end
        ro_prev = reqOut;
    end

    task automatic wait_reqin();
        for (int i = 0; i < 50 && !reqIn; i++) begin
            @(posedge clk); #1;
        end
        check("reqIn_wait", reqIn, 1);
    endtask

    task automatic program_key(input logic [15:0] k);
        prog = 1'b1;
        dataIn = k;
        @(posedge clk); #1;
        prog = 1'b0;
        model_key = k;
        check("prog_key", key, k);
        check("prog_state", state, 1);
        check("prog_reqIn", reqIn, 1);
    endtask

    task automatic send_word(input logic [15:0] c, input logic [3:0] r, input logic [15:0] e,
                             input int cap_hold, input int rdy_late, input bit prog_out);
        wait_reqin();
        exp_q.push_back(e);
        dataIn = c;
        rot_offset = r;
        rdyIn = 1'b1;
        @(posedge clk); #1;
        check("capture_reqIn", reqIn, 0);
        check("capture_state", state, 2);
        if (rdy_late == 0) rdyIn = 1'b0;
        dataIn = 16'($urandom);
        rot_offset = 4'($urandom);
        @(posedge clk); #1;
        check("latency_reqOut", reqOut, 1);
        if (prog_out) begin
            prog = 1'b1;
            dataIn = 16'($urandom);
            @(posedge clk); #1;
            prog = 1'b0;
            check("prog_out_key", key, model_key);
            check("prog_out_dataOut", dataOut, e);
            check("prog_out_reqOut", reqOut, 1);
        end
        cap = 1'b1;
        @(posedge clk); #1;
        check("cap_reqOut", reqOut, 0);
        check("cap_state", state, 4);
        for (int i = 0; i < cap_hold; i++) begin
            @(posedge clk); #1;
            check("cap_hold_reqIn", reqIn, 0);
        end
        cap = 1'b0;
        for (int i = 0; i < rdy_late; i++) begin
            @(posedge clk); #1;
            check("slow_rdy_state", state, 4);
            check("slow_rdy_reqIn", reqIn, 0);
        end
        rdyIn = 1'b0;
        @(posedge clk); #1;
        check("rearm_reqIn", reqIn, 1);
`ifdef DECRYPTER_KEY_ROLL_EN
        model_key = m_rotl(model_key, 1);
`endif
        check("key_after_word", key, model_key);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p, k, c;
        logic [3:0]  r;
        reset = 1'b0;
        dataIn = '0; rot_offset = '0; rdyIn = 0; cap = 0; prog = 0;
        model_key = '0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            dataIn = 16'($urandom); rot_offset = 4'($urandom);
            rdyIn = 1'($urandom); cap = 1'($urandom); prog = 1'($urandom);
            @(posedge clk); #1;
            check("rst_dataOut", dataOut, 0);
            check("rst_reqIn", reqIn, 0);
            check("rst_reqOut", reqOut, 0);
            check("rst_state", state, 0);
            check("rst_key", key, 0);
        end
        dataIn = '0; rot_offset = '0; rdyIn = 0; cap = 0; prog = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_hold_state", state, 0);

        // Directed vectors
        program_key(16'hCCE3);
        send_word(16'hF0F0, 4'd0, 16'h3C13, 0, 0, 0);
        program_key(16'hCCE3);
        send_word(16'hF0F0, 4'd7, 16'h9007, 0, 0, 0);

        // Random round trips through the Encrypter model
        for (int n = 0; n < 100; n++) begin
            p = 16'($urandom); k = 16'($urandom); r = 4'($urandom);
            c = m_enc(p, k, int'(r));
            program_key(k);
            send_word(c, r, p, 0, 0, 0);
        end

        // prog and rdyIn together in REQ, then prog during OUT
        k = 16'($urandom);
        c = 16'($urandom);
        r = 4'($urandom);
        rdyIn = 1'b1;
        program_key(k);
        send_word(c, r, m_dec(c, k, int'(r)), 0, 0, 1);

        // Long cap hold and slow rdyIn release
        c = 16'($urandom);
        r = 4'($urandom);
        send_word(c, r, m_dec(c, model_key, int'(r)), 3, 3, 0);

        // Key roll sequence
        program_key(16'h8001);
        c = 16'($urandom); r = 4'($urandom);
        send_word(c, r, m_dec(c, model_key, int'(r)), 0, 0, 0);
`ifdef DECRYPTER_KEY_ROLL_EN
        check("roll_key1", key, 16'h0003);
`else
        check("roll_key1", key, 16'h8001);
`endif
        c = 16'($urandom); r = 4'($urandom);
        send_word(c, r, m_dec(c, model_key, int'(r)), 0, 0, 0);
`ifdef DECRYPTER_KEY_ROLL_EN
        check("roll_key2", key, 16'h0006);
`else
        check("roll_key2", key, 16'h8001);
`endif

        // Asynchronous reset while in OUT
        wait_reqin();
        c = 16'($urandom); r = 4'($urandom);
        exp_q.push_back(m_dec(c, model_key, int'(r)));
        dataIn = c; rot_offset = r; rdyIn = 1'b1;
        @(posedge clk); #1;
        rdyIn = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_reqOut", reqOut, 1);
        #5;
        reset = 1'b0;
        #1;
        check("async_rst_reqOut", reqOut, 0);
        check("async_rst_state", state, 0);
        check("async_rst_key", key, 0);
        check("async_rst_dataOut", dataOut, 0);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_state", state, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
